hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage (F/D/E/M/W) core. Drives the stall/flush
//  inputs of the pipeline registers (IF/ID, ID/EX, EX/MEM) and the forwarding muxes in E.
//  Sequences trap entry (exception/interrupt) and MRET through a small FSM.
//  Holds the pipeline while the data-memory port is busy.
// PARAMETERS
//  RW        5   register-address width
//  DRAIN_MAX 15  max DRAIN cycles waiting on dmem_busy_i before a trap is forced
// PORTS
//  clk_i           in  1   clock
//  rst_i           in  1   reset, asynchronous, active-high
//  rs1_d_i/rs2_d_i in  RW  source regs of instr in D
//  rs1_e_i/rs2_e_i in  RW  source regs of instr in E
//  rd_e_i/rd_m_i/rd_w_i in RW  dest regs in E/M/W
//  load_e_i        in  1   instr in E is a load
//  reg_write_m_i   in  1   M instr writes rd
//  reg_write_w_i   in  1   W instr writes rd
//  branch_taken_e_i in 1   branch/jump resolved taken in E
//  dmem_busy_i     in  1   data memory not ready; pipeline must freeze
//  exc_m_i         in  1   instr in M raised an exception
//  mret_m_i        in  1   instr in M is MRET
//  irq_i           in  1   enabled interrupt pending (from CSR unit)
//  stall_f_o/stall_d_o out 1  hold PC / IF-ID register
//  stall_all_o     out 1   freeze ID-EX, EX-MEM, MEM-WB
//  flush_d_o/flush_e_o/flush_m_o out 1  insert NOP into IF-ID / ID-EX / EX-MEM
//  fwd_a_e_o/fwd_b_e_o out 2  E-stage operand select (fwd_sel_e)
//  trap_take_o     out 1   1-cycle: CSR saves mepc/mcause, PC <= mtvec
//  mret_take_o     out 1   1-cycle: PC <= mepc
//  drain_timeout_o out 1   1-cycle pulse: DRAIN hit DRAIN_MAX
// BEHAVIOUR
//  Reset: state HZ_RUN, drain counter 0, latched cause 0. All stall/flush/take/timeout outputs 0.
//   Reset mid-operation aborts any sequence immediately.
//  Forwarding (comb): M match (reg_write_m_i, rd_m_i!=0, rd_m_i==rs_e) -> FWD_MEM.
//   Else W match -> FWD_WB. Else FWD_NONE. M has priority over W.
//  Load-use (RUN only): load_e_i & rd_e_i!=0 & rd_e_i in {rs1_d,rs2_d}
//   -> stall_f=stall_d=1, flush_e=1.
//  Branch taken (RUN only): flush_d=flush_e=1. Overrides load-use (stall_f/d=0).
//  Never assert stall_d_o and flush_d_o together: the IF/ID register gives stall priority over flush.
//  dmem_busy_i in RUN: stall_f=stall_d=stall_all=1, all flushes 0. Highest priority.
//   Branch/load-use re-evaluated when busy drops.
//  FSM (registered, hz_state_e):
//   RUN:   event = exc_m_i | mret_m_i | irq_i. Priority exc > mret > irq. Latch kind (trap/mret).
//          On the event cycle: stall_f=stall_d=stall_all=1, flushes 0.
//          Next state is DRAIN if dmem_busy_i, else TRAP or MRET.
//   DRAIN: stall_f=stall_d=stall_all=1. Counter increments each cycle.
//          !dmem_busy_i -> TRAP or MRET.
//          Counter==DRAIN_MAX-1 -> drain_timeout_o=1 that cycle, next state TRAP (cause forced trap).
//   TRAP:  trap_take_o=1, flush_d=flush_e=flush_m=1, stalls 0. Next state RUN, counter cleared.
//   MRET:  as TRAP, with mret_take_o=1 instead of trap_take_o.
//   Events, load-use and branch are ignored outside RUN. Pending irq is re-sampled on return to RUN.
//  Counter width is $clog2(DRAIN_MAX+1). It saturates and never wraps.
// STRUCTURE
//  hazard_pkg: typedef enum logic[1:0] fwd_sel_e {FWD_NONE=00, FWD_WB=01, FWD_MEM=10};
//   typedef enum logic[1:0] hz_state_e {HZ_RUN, HZ_DRAIN, HZ_TRAP, HZ_MRET};
//   localparam NOP_INSTR = 32'h0000_0013.
//  Sub-module fwd_unit: combinational forwarding, instantiated once per operand.
//   FSM, counter and stall/flush priority logic stay in hazard_ctrl.
// TESTING
//  1. rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> fwd_a=FWD_MEM.
//     With reg_write_m=0 -> FWD_WB. With rs1_e=rd_m=0 -> FWD_NONE.
//  2. load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1, flush_d=0 for 1 cycle.
//     Add branch_taken_e the same cycle -> stalls 0, flush_d=flush_e=1.
//  3. exc_m pulse at cycle N, dmem_busy=0 -> N: stall_all=1; N+1: trap_take=1, flush_d/e/m=1;
//     N+2: all 0.
//  4. irq=1 with dmem_busy=1 for 3 cycles -> stall_all held through DRAIN.
//     trap_take=1 the cycle after busy drops, exactly once.
//  5. DRAIN_MAX=4, dmem_busy stuck high after exc_m -> drain_timeout_o on 4th DRAIN cycle,
//     trap_take next cycle.
//     mret_m+exc_m same cycle -> trap_take=1, mret_take=0.
//  6. rst_i asserted while in DRAIN -> all outputs 0 immediately, state RUN, counter 0.
//     A fresh exc_m after reset is sequenced normally.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the pipeline hazard/sequencing logic.
//   fwd_sel_e  : E-stage operand source select (none / write-back / memory stage)
//   hz_state_e : hazard controller sequencing states
//   NOP_INSTR  : instruction word the pipeline inserts when a stage is flushed
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_DRAIN,
    HZ_TRAP,
    HZ_MRET
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit
//   Combinational forwarding select for one E-stage source operand.
//   Ports:
//     rs_e_i        source register of the instruction in E
//     rd_m_i        destination register of the instruction in M
//     reg_write_m_i M instruction writes rd_m_i
//     rd_w_i        destination register of the instruction in W
//     reg_write_w_i W instruction writes rd_w_i
//     fwd_sel_o     operand source: FWD_MEM, FWD_WB or FWD_NONE
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] rs_e_i,
  input  logic [RW-1:0] rd_m_i,
  input  logic          reg_write_m_i,
  input  logic [RW-1:0] rd_w_i,
  input  logic          reg_write_w_i,
  output fwd_sel_e      fwd_sel_o
);

  // The M result is younger than the W result, so it wins when both match.
  // x0 is hardwired to zero and is never forwarded.
  always_comb begin
    fwd_sel_o = FWD_NONE;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Central hazard/sequencing controller for the 5-stage core.
//   Ports:
//     clk_i, rst_i                 clock, asynchronous active-high reset
//     rs1_d_i/rs2_d_i              source registers of the instruction in D
//     rs1_e_i/rs2_e_i              source registers of the instruction in E
//     rd_e_i/rd_m_i/rd_w_i         destination registers in E/M/W
//     load_e_i                     instruction in E is a load
//     reg_write_m_i/reg_write_w_i  M/W instruction writes its rd
//     branch_taken_e_i             branch/jump resolved taken in E
//     dmem_busy_i                  data memory not ready, pipeline freezes
//     exc_m_i/mret_m_i/irq_i       trap/return events seen in M
//     stall_f_o/stall_d_o          hold PC / IF-ID register
//     stall_all_o                  freeze ID-EX, EX-MEM, MEM-WB
//     flush_d_o/flush_e_o/flush_m_o insert NOP into IF-ID / ID-EX / EX-MEM
//     fwd_a_e_o/fwd_b_e_o          E-stage operand forwarding selects
//     trap_take_o/mret_take_o      one-cycle redirect to mtvec / mepc
//     drain_timeout_o              one-cycle pulse when a drain gives up
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RW        = 5,
  parameter int DRAIN_MAX = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [RW-1:0] rs1_d_i,
  input  logic [RW-1:0] rs2_d_i,
  input  logic [RW-1:0] rs1_e_i,
  input  logic [RW-1:0] rs2_e_i,
  input  logic [RW-1:0] rd_e_i,
  input  logic [RW-1:0] rd_m_i,
  input  logic [RW-1:0] rd_w_i,
  input  logic          load_e_i,
  input  logic          reg_write_m_i,
  input  logic          reg_write_w_i,
  input  logic          branch_taken_e_i,
  input  logic          dmem_busy_i,
  input  logic          exc_m_i,
  input  logic          mret_m_i,
  input  logic          irq_i,
  output logic          stall_f_o,
  output logic          stall_d_o,
  output logic          stall_all_o,
  output logic          flush_d_o,
  output logic          flush_e_o,
  output logic          flush_m_o,
  output fwd_sel_e      fwd_a_e_o,
  output fwd_sel_e      fwd_b_e_o,
  output logic          trap_take_o,
  output logic          mret_take_o,
  output logic          drain_timeout_o
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  hz_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // 1 = the pending sequence is an MRET, 0 = a trap
  logic cause_q, cause_d;

  logic sf, sd, sa, fd, fe, fm, tt, mt, to;
  logic event_m, load_use;

  fwd_unit #(.RW(RW)) u_fwd_a (
    .rs_e_i        (rs1_e_i),
    .rd_m_i        (rd_m_i),
    .reg_write_m_i (reg_write_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_sel_o     (fwd_a_e_o)
  );

  fwd_unit #(.RW(RW)) u_fwd_b (
    .rs_e_i        (rs2_e_i),
    .rd_m_i        (rd_m_i),
    .reg_write_m_i (reg_write_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_sel_o     (fwd_b_e_o)
  );

  assign event_m  = exc_m_i | mret_m_i | irq_i;
  assign load_use = load_e_i && (rd_e_i != '0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next state plus raw control outputs. In RUN the priority is
  // event > memory busy > taken branch > load-use; a taken branch squashes
  // the load-use stall because the stalled instruction is on the wrong path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    sf = 1'b0; sd = 1'b0; sa = 1'b0;
    fd = 1'b0; fe = 1'b0; fm = 1'b0;
    tt = 1'b0; mt = 1'b0; to = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        cnt_d = '0;
        if (event_m) begin
          sf = 1'b1; sd = 1'b1; sa = 1'b1;
          cause_d = !exc_m_i && mret_m_i;
          if (dmem_busy_i)                   state_d = HZ_DRAIN;
          else if (!exc_m_i && mret_m_i)     state_d = HZ_MRET;
          else                               state_d = HZ_TRAP;
        end else if (dmem_busy_i) begin
          sf = 1'b1; sd = 1'b1; sa = 1'b1;
        end else if (branch_taken_e_i) begin
          fd = 1'b1; fe = 1'b1;
        end else if (load_use) begin
          sf = 1'b1; sd = 1'b1; fe = 1'b1;
        end
      end
      HZ_DRAIN: begin
        sf = 1'b1; sd = 1'b1; sa = 1'b1;
        if (cnt_q != CW'(DRAIN_MAX)) cnt_d = cnt_q + CW'(1);
        // A memory that finally answers wins over the timeout in the same cycle.
        if (!dmem_busy_i) begin
          state_d = cause_q ? HZ_MRET : HZ_TRAP;
        end else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
          to      = 1'b1;
          cause_d = 1'b0;
          state_d = HZ_TRAP;
        end
      end
      HZ_TRAP: begin
        tt = 1'b1; fd = 1'b1; fe = 1'b1; fm = 1'b1;
        cnt_d   = '0;
        state_d = HZ_RUN;
      end
      HZ_MRET: begin
        mt = 1'b1; fd = 1'b1; fe = 1'b1; fm = 1'b1;
        cnt_d   = '0;
        state_d = HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Held low throughout reset, so the pipeline sees no stall or flush
  // while busy/event inputs are still settling.
  assign stall_f_o       = sf & ~rst_i;
  assign stall_d_o       = sd & ~rst_i;
  assign stall_all_o     = sa & ~rst_i;
  assign flush_d_o       = fd & ~rst_i;
  assign flush_e_o       = fe & ~rst_i;
  assign flush_m_o       = fm & ~rst_i;
  assign trap_take_o     = tt & ~rst_i;
  assign mret_take_o     = mt & ~rst_i;
  assign drain_timeout_o = to & ~rst_i;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. Directed scenarios and random
//   traffic are checked every cycle against a transaction-level model.
module tb_hazard_ctrl;

  localparam int RW        = 5;
  localparam int DRAIN_MAX = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [RW-1:0] rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, rd_m_i, rd_w_i;
  logic load_e_i, reg_write_m_i, reg_write_w_i, branch_taken_e_i;
  logic dmem_busy_i, exc_m_i, mret_m_i, irq_i;
  logic stall_f_o, stall_d_o, stall_all_o, flush_d_o, flush_e_o, flush_m_o;
  logic [1:0] fwd_a_e_o, fwd_b_e_o;
  logic trap_take_o, mret_take_o, drain_timeout_o;

  int checks   = 0;
  int failures = 0;

  // Model: what the controller owes the pipeline.
  // m_take: 0 nothing pending, 1 trap redirect next, 2 mret redirect next
  int m_take;
  bit m_drain;
  int m_drain_cycles;
  int m_kind;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.RW(RW), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rs1_d_i         (rs1_d_i),
    .rs2_d_i         (rs2_d_i),
    .rs1_e_i         (rs1_e_i),
    .rs2_e_i         (rs2_e_i),
    .rd_e_i          (rd_e_i),
    .rd_m_i          (rd_m_i),
    .rd_w_i          (rd_w_i),
    .load_e_i        (load_e_i),
    .reg_write_m_i   (reg_write_m_i),
    .reg_write_w_i   (reg_write_w_i),
    .branch_taken_e_i(branch_taken_e_i),
    .dmem_busy_i     (dmem_busy_i),
    .exc_m_i         (exc_m_i),
    .mret_m_i        (mret_m_i),
    .irq_i           (irq_i),
    .stall_f_o       (stall_f_o),
    .stall_d_o       (stall_d_o),
    .stall_all_o     (stall_all_o),
    .flush_d_o       (flush_d_o),
    .flush_e_o       (flush_e_o),
    .flush_m_o       (flush_m_o),
    .fwd_a_e_o       (fwd_a_e_o),
    .fwd_b_e_o       (fwd_b_e_o),
    .trap_take_o     (trap_take_o),
    .mret_take_o     (mret_take_o),
    .drain_timeout_o (drain_timeout_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdRef(input logic [RW-1:0] rs);
    if (reg_write_m_i && rd_m_i != 0 && rd_m_i == rs) return 2'b10;
    if (reg_write_w_i && rd_w_i != 0 && rd_w_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clearInputs();
    rs1_d_i = '0; rs2_d_i = '0; rs1_e_i = '0; rs2_e_i = '0;
    rd_e_i = '0; rd_m_i = '0; rd_w_i = '0;
    load_e_i = 0; reg_write_m_i = 0; reg_write_w_i = 0; branch_taken_e_i = 0;
    dmem_busy_i = 0; exc_m_i = 0; mret_m_i = 0; irq_i = 0;
  endtask

  task automatic applyStimulus();
    rs1_d_i = RW'($urandom_range(0, 7)); rs2_d_i = RW'($urandom_range(0, 7));
    rs1_e_i = RW'($urandom_range(0, 7)); rs2_e_i = RW'($urandom_range(0, 7));
    rd_e_i  = RW'($urandom_range(0, 7)); rd_m_i  = RW'($urandom_range(0, 7));
    rd_w_i  = RW'($urandom_range(0, 7));
    load_e_i         = ($urandom_range(0, 2) == 0);
    reg_write_m_i    = $urandom_range(0, 1);
    reg_write_w_i    = $urandom_range(0, 1);
    branch_taken_e_i = ($urandom_range(0, 3) == 0);
    dmem_busy_i      = ($urandom_range(0, 3) == 0);
    exc_m_i          = ($urandom_range(0, 19) == 0);
    mret_m_i         = ($urandom_range(0, 19) == 0);
    irq_i            = ($urandom_range(0, 15) == 0);
  endtask

  task automatic checkAll(input string ph);
    logic e_sf, e_sd, e_sa, e_fd, e_fe, e_fm, e_tt, e_mt, e_to;
    {e_sf, e_sd, e_sa, e_fd, e_fe, e_fm, e_tt, e_mt, e_to} = '0;
    if (!rst_i) begin
      if (m_take != 0) begin
        e_fd = 1; e_fe = 1; e_fm = 1;
        e_tt = (m_take == 1);
        e_mt = (m_take == 2);
      end else if (m_drain) begin
        e_sf = 1; e_sd = 1; e_sa = 1;
        e_to = dmem_busy_i && (m_drain_cycles == DRAIN_MAX - 1);
      end else if (exc_m_i || mret_m_i || irq_i || dmem_busy_i) begin
        e_sf = 1; e_sd = 1; e_sa = 1;
      end else if (branch_taken_e_i) begin
        e_fd = 1; e_fe = 1;
      end else if (load_e_i && rd_e_i != 0 && (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i)) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
    end
    checkOutput({ph, ".stall_f"},   32'(stall_f_o),       32'(e_sf));
    checkOutput({ph, ".stall_d"},   32'(stall_d_o),       32'(e_sd));
    checkOutput({ph, ".stall_all"}, 32'(stall_all_o),     32'(e_sa));
    checkOutput({ph, ".flush_d"},   32'(flush_d_o),       32'(e_fd));
    checkOutput({ph, ".flush_e"},   32'(flush_e_o),       32'(e_fe));
    checkOutput({ph, ".flush_m"},   32'(flush_m_o),       32'(e_fm));
    checkOutput({ph, ".trap_take"}, 32'(trap_take_o),     32'(e_tt));
    checkOutput({ph, ".mret_take"}, 32'(mret_take_o),     32'(e_mt));
    checkOutput({ph, ".timeout"},   32'(drain_timeout_o), 32'(e_to));
    checkOutput({ph, ".fwd_a"},     32'(fwd_a_e_o),       32'(fwdRef(rs1_e_i)));
    checkOutput({ph, ".fwd_b"},     32'(fwd_b_e_o),       32'(fwdRef(rs2_e_i)));
    checkOutput({ph, ".no_stall_and_flush_d"}, 32'(stall_d_o & flush_d_o), 32'd0);
  endtask

  task automatic updateModel();
    if (rst_i) begin
      m_take = 0; m_drain = 0; m_drain_cycles = 0; m_kind = 1;
    end else if (m_take != 0) begin
      m_take = 0;
    end else if (m_drain) begin
      if (!dmem_busy_i) begin
        m_take = m_kind; m_drain = 0;
      end else if (m_drain_cycles == DRAIN_MAX - 1) begin
        m_take = 1; m_drain = 0;
      end else begin
        m_drain_cycles++;
      end
    end else if (exc_m_i || mret_m_i || irq_i) begin
      m_kind = exc_m_i ? 1 : (mret_m_i ? 2 : 1);
      if (dmem_busy_i) begin
        m_drain = 1; m_drain_cycles = 0;
      end else begin
        m_take = m_kind;
      end
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic stepCycle(input string ph);
    @(negedge clk_i);
    checkAll(ph);
    @(posedge clk_i);
    updateModel();
    #1;
  endtask

  initial begin
    $display("[TB] hazard_ctrl bench start");
    clearInputs();
    rst_i = 1'b1;
    updateModel();
    dmem_busy_i = 1; exc_m_i = 1;
    repeat (2) stepCycle("reset");
    clearInputs();
    rst_i = 1'b0;

    // Forwarding priority
    rd_m_i = 5; reg_write_m_i = 1; rd_w_i = 5; reg_write_w_i = 1; rs1_e_i = 5; rs2_e_i = 5;
    stepCycle("fwd_mem");
    reg_write_m_i = 0;
    stepCycle("fwd_wb");
    rs1_e_i = 0; rd_m_i = 0; rd_w_i = 0; reg_write_m_i = 1;
    stepCycle("fwd_x0");
    clearInputs();

    // Load-use, then branch overriding it
    load_e_i = 1; rd_e_i = 7; rs2_d_i = 7;
    stepCycle("load_use");
    branch_taken_e_i = 1;
    stepCycle("branch_over_lu");
    clearInputs();
    stepCycle("idle");

    // Exception with memory idle
    exc_m_i = 1;
    stepCycle("exc_n");
    exc_m_i = 0;
    stepCycle("exc_n1");
    stepCycle("exc_n2");

    // Interrupt while memory busy
    irq_i = 1; dmem_busy_i = 1;
    repeat (3) stepCycle("irq_drain");
    dmem_busy_i = 0;
    stepCycle("irq_release");
    irq_i = 0;
    repeat (3) stepCycle("irq_take");

    // Drain timeout with memory stuck
    exc_m_i = 1; dmem_busy_i = 1;
    stepCycle("to_event");
    exc_m_i = 0;
    repeat (6) stepCycle("to_drain");
    dmem_busy_i = 0;
    stepCycle("to_idle");

    // MRET and exception together
    mret_m_i = 1; exc_m_i = 1;
    stepCycle("mret_exc");
    clearInputs();
    repeat (2) stepCycle("mret_exc_take");

    // Plain MRET through a drain
    mret_m_i = 1; dmem_busy_i = 1;
    stepCycle("mret_ev");
    mret_m_i = 0;
    stepCycle("mret_drain");
    dmem_busy_i = 0;
    repeat (3) stepCycle("mret_take");

    // Reset in the middle of a drain
    exc_m_i = 1; dmem_busy_i = 1;
    stepCycle("rst_ev");
    exc_m_i = 0;
    repeat (2) stepCycle("rst_drain");
    #2 rst_i = 1'b1;
    #1 checkAll("rst_async");
    @(posedge clk_i);
    updateModel();
    #1 rst_i = 1'b0;
    dmem_busy_i = 0;
    stepCycle("post_rst");
    exc_m_i = 1; dmem_busy_i = 1;
    stepCycle("post_rst_ev");
    exc_m_i = 0;
    repeat (5) stepCycle("post_rst_drain");
    clearInputs();
    repeat (2) stepCycle("post_rst_idle");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
